bram_drain_sched: RTL
=====================

Name: bram_drain_sched

Overview:
- Readout scheduler for the receiver's ping-pong capture BRAMs (bank A = MEM1, bank B = MEM2).
- Runs once the capture controller reports a finished capture (rdy != 00, capture idle). Claims both banks through rdy_w and reads size_data words: bank A first, then bank B.
- Streams the words out on an AXI-Stream-style master toward the DMA/host path, then releases the banks so the capture controller can re-arm on the next sinc edge.

Parameters:
- DATA_W, 32, sample word width.
- BANK_DEPTH, 2048, words per bank; bank B holds word indices BANK_DEPTH..2*BANK_DEPTH-1.
- RD_LAT, 2, fixed BRAM read latency in cycles from bram_en/addr to dout valid.
- FIFO_DEPTH, 4, output skid FIFO depth; must be >= RD_LAT+1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rdy  in  2  bank-full flags from capture controller: 00 none, 01 bank A, 11 both.
- cap_busy  in  1  capture controller writing (en_a|en_b).
- size_data  in  32  valid words in the capture.
- rdy_w  out  2  bank ownership flags to capture controller; 00 = free.
- bram_en_a  out  1  bank A read enable.
- bram_en_b  out  1  bank B read enable.
- bram_addr  out  32  byte address within the bank (word index*4).
- bram_dout_a  in  DATA_W  bank A read data.
- bram_dout_b  in  DATA_W  bank B read data.
- m_tdata  out  DATA_W  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  marks the last word of the capture.
- busy  out  1  high from claim until release.
- frame_cnt  out  16  completed drains; wraps at 65535->0.

Behaviour:
- Clock and reset:
  - One clock domain (clk). Reset is synchronous and active-high (rst).
  - Reset values: rdy_w=00, bram_en_a=0, bram_en_b=0, bram_addr=0, m_tvalid=0, m_tlast=0, busy=0, frame_cnt=0, armed=0.
  - Reset clears the FIFO and all in-flight reads, whatever state the block is in.
- armed flag:
  - Set on any cycle where cap_busy=1 or rdy=00.
  - Cleared when a drain is claimed.
  - Prevents re-draining a rdy value the capture controller still holds.
- States: IDLE, CLAIM, READ, FLUSH, RELEASE.
- IDLE -> CLAIM when armed & !cap_busy & rdy!=00. In CLAIM:
  - Latch total = min(size_data, rdy==11 ? 2*BANK_DEPTH : BANK_DEPTH).
  - Set rdy_w=rdy, busy=1, clear armed.
  - If total==0, go to RELEASE; otherwise go to READ (1 cycle).
- READ:
  - Issue one read per cycle while credits are available. credit = FIFO_DEPTH - fifo_count - reads_in_flight.
  - Word index i runs 0..total-1.
  - i < BANK_DEPTH: bram_en_a=1, bram_addr=i*4.
  - i >= BANK_DEPTH: bram_en_b=1, bram_addr=(i-BANK_DEPTH)*4.
  - bram_en_a and bram_en_b are never high together. Both are low when no read is issued.
  - After issuing index total-1, go to FLUSH.
- Data return:
  - A delayed bank-select/valid shift register (RD_LAT stages) captures the correct dout into the FIFO exactly RD_LAT cycles after the issue.
  - The tlast tag travels with the word index total-1.
- Output:
  - First-word-fall-through from the FIFO: m_tvalid = FIFO not empty.
  - A word transfers when m_tvalid & m_tready.
  - m_tdata and m_tlast hold stable while m_tvalid=1 & m_tready=0.
- FLUSH -> RELEASE when the tlast word transfers.
- RELEASE (1 cycle):
  - rdy_w=00, busy=0.
  - frame_cnt+1, except when total==0.
  - Then go to IDLE.
- Latency: the first m_tvalid comes RD_LAT+1 cycles after CLAIM.
- Sustained throughput: 1 word/clk while m_tready=1.
- Boundaries:
  - size_data > limit is clamped silently.
  - total==BANK_DEPTH: bank B is never enabled.
  - rdy changing while busy is ignored; total was latched in CLAIM.
  - cap_busy rising while busy is ignored; the capture controller is blocked by rdy_w!=00.

Decomposition:
- Shared receiver package holds:
  - State encoding constants: IDLE=3'd0, CLAIM=1, READ=2, FLUSH=3, RELEASE=4.
  - Bank-flag constants: RDY_NONE=2'b00, RDY_A=2'b01, RDY_AB=2'b11.
  - Default BANK_DEPTH.
- One sub-module: sync_fifo_fwft (parameters DATA_W+1, FIFO_DEPTH; outputs count, empty, full).

Test Plan:
- rdy=11, size_data=4096, m_tready=1 -> 4096 beats in 4096 consecutive cycles; words 0..2047 from bank A at addr 0..8188, then bank B; tlast on beat 4096; rdy_w 11->00; frame_cnt=1.
- rdy=01, size_data=5000 -> clamped to 2048 beats; bram_en_b never high; rdy_w 01->00.
- rdy=11, size_data=2100, m_tready toggling 1/0 every cycle -> exactly 2100 beats, no loss or duplication; m_tdata stable while stalled; 52 beats come from bank B.
- After completion, rdy held at 11 and cap_busy=0 for 100 cycles -> no second claim. Then cap_busy pulse, rdy=11 -> new drain, frame_cnt=2.
- rdy=01, size_data=0 -> rdy_w=01 for one cycle then 00; no beats; frame_cnt unchanged.
- rst asserted for 1 cycle mid-READ at beat 500 -> next cycle all outputs at reset values; FIFO empty; no claim until cap_busy=1 or rdy=00 is seen.

Source files
------------

// File: rtl/bram_drain_sched_pkg.sv
// Shared receiver definitions: drain FSM encoding, bank-full flag values and
// the default bank size, plus the capture-length clamp used when claiming.
package bram_drain_sched_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLAIM   = 3'd1,
      READ    = 3'd2,
      FLUSH   = 3'd3,
      RELEASE = 3'd4
   } state_e;

   localparam logic [1:0] RDY_NONE = 2'b00;
   localparam logic [1:0] RDY_A    = 2'b01;
   localparam logic [1:0] RDY_AB   = 2'b11;

   localparam int BANK_DEPTH_DEF = 2048;

   // A capture can never be longer than the banks the controller marked full.
   function automatic logic [31:0] clamp_total(input logic [31:0] size,
                                               input logic [1:0]  rdy_flags,
                                               input int          bank_depth);
      logic [31:0] limit;
      limit = (rdy_flags == RDY_AB) ? 32'(2 * bank_depth) : 32'(bank_depth);
      return (size > limit) ? limit : size;
   endfunction

endpackage

// File: rtl/bram_drain_sched_fifo.sv
// First-word-fall-through synchronous FIFO; rd_data_o shows the head entry
// whenever empty_o is low and rd_en_i pops it.
module sync_fifo_fwft #(
   parameter int DATA_W = 33,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en_i,
   input  logic [DATA_W-1:0]          wr_data_i,
   input  logic                       rd_en_i,
   output logic [DATA_W-1:0]          rd_data_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       empty_o,
   output logic                       full_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_wr, do_rd;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == CNT_W'(DEPTH));
   assign count_o   = count_q;
   assign rd_data_o = mem_q[rd_ptr_q];
   assign do_wr     = wr_en_i & ~full_o;
   assign do_rd     = rd_en_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      if (do_wr && !do_rd)      count_d = count_q + CNT_W'(1);
      else if (!do_wr && do_rd) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/bram_drain_sched.sv
// Drains a finished ping-pong capture (bank A then bank B) onto a stream
// master, holding bank ownership through rdy_w until the tlast word leaves.
module bram_drain_sched
   import bram_drain_sched_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int BANK_DEPTH = BANK_DEPTH_DEF,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        rdy,
   input  logic              cap_busy,
   input  logic [31:0]       size_data,
   output logic [1:0]        rdy_w,
   output logic              bram_en_a,
   output logic              bram_en_b,
   output logic [31:0]       bram_addr,
   input  logic [DATA_W-1:0] bram_dout_a,
   input  logic [DATA_W-1:0] bram_dout_b,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic              busy,
   output logic [15:0]       frame_cnt,
   output logic [2:0]        dbg_state
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int OCC_W = 8;

   state_e            state_q, state_d;
   logic [31:0]       total_q, total_d, idx_q, idx_d, claim_total;
   logic [1:0]        rdy_w_q, rdy_w_d;
   logic              busy_q, busy_d, armed_q, armed_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic [RD_LAT-1:0] sr_valid_q, sr_bank_b_q, sr_last_q;
   logic              issue, issue_last, issue_bank_b, last_beat;
   logic [OCC_W-1:0]  inflight, occupancy;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty, fifo_full;
   logic [DATA_W:0]   fifo_wr_data, fifo_rd_data;

   assign claim_total = clamp_total(size_data, rdy, BANK_DEPTH);

   // Credit = FIFO slots not already promised to stored or in-flight words.
   always_comb begin
      inflight = '0;
      for (int k = 0; k < RD_LAT; k++) inflight = inflight + OCC_W'(sr_valid_q[k]);
      occupancy = inflight + OCC_W'(fifo_count);
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (armed_q && !cap_busy && rdy != RDY_NONE) state_d = CLAIM;
         CLAIM:   state_d = (claim_total == '0) ? RELEASE : READ;
         READ:    if (issue && issue_last) state_d = FLUSH;
         FLUSH:   if (last_beat) state_d = RELEASE;
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      issue        = 1'b0;
      issue_last   = 1'b0;
      issue_bank_b = 1'b0;
      bram_en_a    = 1'b0;
      bram_en_b    = 1'b0;
      bram_addr    = '0;
      if (state_q == READ && occupancy < OCC_W'(FIFO_DEPTH) && !fifo_full) begin
         issue      = 1'b1;
         issue_last = (idx_q == total_q - 32'd1);
         if (idx_q < 32'(BANK_DEPTH)) begin
            bram_en_a = 1'b1;
            bram_addr = idx_q << 2;
         end else begin
            bram_en_b    = 1'b1;
            issue_bank_b = 1'b1;
            bram_addr    = (idx_q - 32'(BANK_DEPTH)) << 2;
         end
      end
   end

   always_comb begin
      total_d     = total_q;
      idx_d       = idx_q;
      rdy_w_d     = rdy_w_q;
      busy_d      = busy_q;
      frame_cnt_d = frame_cnt_q;
      armed_d     = armed_q | cap_busy | (rdy == RDY_NONE);
      case (state_q)
         CLAIM: begin
            total_d = claim_total;
            idx_d   = '0;
            rdy_w_d = rdy;
            busy_d  = 1'b1;
            armed_d = 1'b0;
         end
         READ:    if (issue) idx_d = idx_q + 32'd1;
         RELEASE: begin
            rdy_w_d = RDY_NONE;
            busy_d  = 1'b0;
            if (total_q != '0) frame_cnt_d = frame_cnt_q + 16'd1;
         end
         default: ;
      endcase
   end

   // The delay line mirrors the BRAM pipeline so dout is sampled on its valid cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         total_q     <= '0;
         idx_q       <= '0;
         rdy_w_q     <= RDY_NONE;
         busy_q      <= 1'b0;
         armed_q     <= 1'b0;
         frame_cnt_q <= '0;
         sr_valid_q  <= '0;
         sr_bank_b_q <= '0;
         sr_last_q   <= '0;
      end else begin
         total_q     <= total_d;
         idx_q       <= idx_d;
         rdy_w_q     <= rdy_w_d;
         busy_q      <= busy_d;
         armed_q     <= armed_d;
         frame_cnt_q <= frame_cnt_d;
         sr_valid_q  <= (sr_valid_q << 1) | RD_LAT'(issue);
         sr_bank_b_q <= (sr_bank_b_q << 1) | RD_LAT'(issue_bank_b);
         sr_last_q   <= (sr_last_q << 1) | RD_LAT'(issue & issue_last);
      end
   end

   assign fifo_wr_data = {sr_last_q[RD_LAT-1],
                          sr_bank_b_q[RD_LAT-1] ? bram_dout_b : bram_dout_a};

   sync_fifo_fwft #(
      .DATA_W (DATA_W + 1),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (sr_valid_q[RD_LAT-1]),
      .wr_data_i (fifo_wr_data),
      .rd_en_i   (m_tready),
      .rd_data_o (fifo_rd_data),
      .count_o   (fifo_count),
      .empty_o   (fifo_empty),
      .full_o    (fifo_full)
   );

   assign m_tvalid  = ~fifo_empty;
   assign m_tdata   = fifo_rd_data[DATA_W-1:0];
   assign m_tlast   = fifo_rd_data[DATA_W] & ~fifo_empty;
   assign last_beat = m_tvalid & m_tready & m_tlast;
   assign rdy_w     = rdy_w_q;
   assign busy      = busy_q;
   assign frame_cnt = frame_cnt_q;
   assign dbg_state = state_q;

endmodule
